// File: rtl/calc_key_sequencer.sv
// rtl/calc_key_sequencer.sv - keypad entry sequencer for the 4-digit BCD calculator (optional CALC_CHAIN_EN)
// Define CALC_CHAIN_EN to let an operator key in RESULT chain the result into operand A.
module calc_key_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [4:0]  key_code,
    input  logic [15:0] result,
    output logic [3:0]  A1,
    output logic [3:0]  A2,
    output logic [3:0]  A3,
    output logic [3:0]  A4,
    output logic [3:0]  B1,
    output logic [3:0]  B2,
    output logic [3:0]  B3,
    output logic [3:0]  B4,
    output logic [1:0]  ST,
    output logic [2:0]  ST_L,
    output logic [15:0] disp,
    output logic        res_valid,
    output logic        key_err
);

    localparam logic [1:0] S_OBL  = 2'b10;
    localparam logic [2:0] SL_ADD = 3'd0;
    localparam logic [2:0] SL_SUB = 3'd1;
    localparam logic [2:0] SL_XOR = 3'd2;
    localparam logic [2:0] SL_AND = 3'd3;
    localparam logic [2:0] SL_OR  = 3'd4;

    localparam logic [4:0] K_EQUALS = 5'd15;
    localparam logic [4:0] K_CLEAR  = 5'd16;
    localparam logic [4:0] K_BKSP   = 5'd17;

    typedef enum logic [1:0] {
        ENTRY_A = 2'b00,
        ENTRY_B = 2'b01,
        RESULT  = S_OBL
    } state_t;

    state_t      state, state_n;
    logic [15:0] a_reg, a_n;        // {A1,A2,A3,A4}, thousands first
    logic [15:0] b_reg, b_n;
    logic [2:0]  a_cnt, a_cnt_n;
    logic [2:0]  b_cnt, b_cnt_n;
    logic [2:0]  op_reg, op_n;
    logic        res_valid_n;
    logic        key_err_n;

    logic        is_digit;
    logic        is_op;
    logic [2:0]  op_code;
    logic [15:0] result_word;

    function automatic logic [2:0] op_sel(input logic [4:0] k);
        case (k)
            5'd10:   op_sel = SL_ADD;
            5'd11:   op_sel = SL_SUB;
            5'd12:   op_sel = SL_XOR;
            5'd13:   op_sel = SL_AND;
            default: op_sel = SL_OR;
        endcase
    endfunction

    assign is_digit    = (key_code <= 5'd9);
    assign is_op       = (key_code >= 5'd10) && (key_code <= 5'd14);
    assign op_code     = op_sel(key_code);
    // Datapath delivers ones in the top nibble; display wants thousands first.
    assign result_word = {result[3:0], result[7:4], result[11:8], result[15:12]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ENTRY_A;
            a_reg     <= 16'h0000;
            b_reg     <= 16'h0000;
            a_cnt     <= 3'd0;
            b_cnt     <= 3'd0;
            op_reg    <= SL_ADD;
            res_valid <= 1'b0;
            key_err   <= 1'b0;
        end else begin
            state     <= state_n;
            a_reg     <= a_n;
            b_reg     <= b_n;
            a_cnt     <= a_cnt_n;
            b_cnt     <= b_cnt_n;
            op_reg    <= op_n;
            res_valid <= res_valid_n;
            key_err   <= key_err_n;
        end
    end

    always_comb begin
        state_n     = state;
        a_n         = a_reg;
        b_n         = b_reg;
        a_cnt_n     = a_cnt;
        b_cnt_n     = b_cnt;
        op_n        = op_reg;
        res_valid_n = 1'b0;
        key_err_n   = 1'b0;

        if (key_valid) begin
            if (key_code == K_CLEAR) begin
                state_n = ENTRY_A;
                a_n     = 16'h0000;
                b_n     = 16'h0000;
                a_cnt_n = 3'd0;
                b_cnt_n = 3'd0;
                op_n    = SL_ADD;
            end else if (key_code > K_BKSP) begin
                key_err_n = 1'b1;
            end else begin
                case (state)
                    ENTRY_A: begin
                        if (is_digit) begin
                            if (a_cnt < 3'd4) begin
                                a_n     = {a_reg[11:0], key_code[3:0]};
                                a_cnt_n = a_cnt + 3'd1;
                            end else begin
                                key_err_n = 1'b1;
                            end
                        end else if (key_code == K_BKSP) begin
                            a_n = {4'h0, a_reg[15:4]};
                            if (a_cnt != 3'd0) a_cnt_n = a_cnt - 3'd1;
                        end else if (is_op) begin
                            op_n    = op_code;
                            b_n     = 16'h0000;
                            b_cnt_n = 3'd0;
                            state_n = ENTRY_B;
                        end else begin
                            key_err_n = 1'b1;
                        end
                    end
                    ENTRY_B: begin
                        if (is_digit) begin
                            if (b_cnt < 3'd4) begin
                                b_n     = {b_reg[11:0], key_code[3:0]};
                                b_cnt_n = b_cnt + 3'd1;
                            end else begin
                                key_err_n = 1'b1;
                            end
                        end else if (key_code == K_BKSP) begin
                            b_n = {4'h0, b_reg[15:4]};
                            if (b_cnt != 3'd0) b_cnt_n = b_cnt - 3'd1;
                        end else if (is_op) begin
                            op_n = op_code;
                        end else begin
                            state_n     = RESULT;
                            res_valid_n = 1'b1;
                        end
                    end
                    RESULT: begin
                        if (is_digit) begin
                            a_n     = {12'h000, key_code[3:0]};
                            a_cnt_n = 3'd1;
                            b_n     = 16'h0000;
                            b_cnt_n = 3'd0;
                            state_n = ENTRY_A;
                        end else if (is_op) begin
`ifdef CALC_CHAIN_EN
                            a_n     = result_word;
                            a_cnt_n = 3'd4;
                            op_n    = op_code;
                            b_n     = 16'h0000;
                            b_cnt_n = 3'd0;
                            state_n = ENTRY_B;
`else
                            key_err_n = 1'b1;
`endif
                        end else begin
                            key_err_n = 1'b1;
                        end
                    end
                    default: begin
                        state_n = ENTRY_A;
                    end
                endcase
            end
        end
    end

    always_comb begin
        case (state)
            ENTRY_B: disp = b_reg;
            RESULT:  disp = result_word;
            default: disp = a_reg;
        endcase
    end

    assign A1   = a_reg[15:12];
    assign A2   = a_reg[11:8];
    assign A3   = a_reg[7:4];
    assign A4   = a_reg[3:0];
    assign B1   = b_reg[15:12];
    assign B2   = b_reg[11:8];
    assign B3   = b_reg[7:4];
    assign B4   = b_reg[3:0];
    assign ST   = state;
    assign ST_L = op_reg;

endmodule

// File: tb/tb_calc_key_sequencer.sv
// tb/tb_calc_key_sequencer.sv - directed self-checking bench for calc_key_sequencer
module tb_calc_key_sequencer;

    localparam logic [2:0] SL_ADD = 3'd0;
    localparam logic [2:0] SL_SUB = 3'd1;
    localparam logic [2:0] SL_AND = 3'd3;
    localparam logic [2:0] SL_OR  = 3'd4;

    localparam logic [4:0] K_ADD = 5'd10, K_SUB = 5'd11, K_AND = 5'd13, K_OR = 5'd14;
    localparam logic [4:0] K_EQ  = 5'd15, K_CLR = 5'd16, K_BS  = 5'd17, K_BAD = 5'd18;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_valid;
    logic [4:0]  key_code;
    logic [15:0] result;
    logic [3:0]  A1, A2, A3, A4, B1, B2, B3, B4;
    logic [1:0]  ST;
    logic [2:0]  ST_L;
    logic [15:0] disp;
    logic        res_valid;
    logic        key_err;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    calc_key_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_code  (key_code),
        .result    (result),
        .A1        (A1),
        .A2        (A2),
        .A3        (A3),
        .A4        (A4),
        .B1        (B1),
        .B2        (B2),
        .B3        (B3),
        .B4        (B4),
        .ST        (ST),
        .ST_L      (ST_L),
        .disp      (disp),
        .res_valid (res_valid),
        .key_err   (key_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] st, input logic [2:0] stl,
                             input logic [15:0] a, input logic [15:0] b,
                             input logic rv, input logic ke);
        check({tag, ".ST"}, ST, st);
        check({tag, ".ST_L"}, ST_L, stl);
        check({tag, ".A"}, {A1, A2, A3, A4}, a);
        check({tag, ".B"}, {B1, B2, B3, B4}, b);
        check({tag, ".res_valid"}, res_valid, rv);
        check({tag, ".key_err"}, key_err, ke);
    endtask

    task automatic press(input logic [4:0] code);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = code;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; key_valid = 1'b0; key_code = 5'd0; result = 16'h0000;
        #12;
        check_all("reset", 2'b00, SL_ADD, 16'h0000, 16'h0000, 1'b0, 1'b0);
        @(negedge clk); rst_n = 1'b1;

        // 123 + 45 =
        press(5'd1); press(5'd2); press(5'd3);
        check_all("a123", 2'b00, SL_ADD, 16'h0123, 16'h0000, 1'b0, 1'b0);
        check("a123.disp", disp, 16'h0123);
        press(K_ADD);
        check_all("op_add", 2'b01, SL_ADD, 16'h0123, 16'h0000, 1'b0, 1'b0);
        press(5'd4); press(5'd5);
        check("b45.disp", disp, 16'h0045);
        result = 16'h8610;
        press(K_EQ);
        check_all("eq", 2'b10, SL_ADD, 16'h0123, 16'h0045, 1'b1, 1'b0);
        check("eq.disp", disp, 16'h0168);
        idle();
        check("eq.res_valid_drop", res_valid, 1'b0);

        result = 16'h5000;
        press(K_SUB);
`ifdef CALC_CHAIN_EN
        check_all("chain", 2'b01, SL_SUB, 16'h0005, 16'h0000, 1'b0, 1'b0);
`else
        check_all("nochain", 2'b10, SL_ADD, 16'h0123, 16'h0045, 1'b0, 1'b1);
`endif
        press(K_CLR);
        check_all("clear1", 2'b00, SL_ADD, 16'h0000, 16'h0000, 1'b0, 1'b0);

        // overflow, consecutive rejects, backspace
        press(5'd9); press(5'd9); press(5'd9); press(5'd9);
        check_all("a9999", 2'b00, SL_ADD, 16'h9999, 16'h0000, 1'b0, 1'b0);
        press(5'd7);
        check_all("a_over1", 2'b00, SL_ADD, 16'h9999, 16'h0000, 1'b0, 1'b1);
        press(5'd7);
        check("a_over2.key_err", key_err, 1'b1);
        press(K_BS);
        check_all("a_bs", 2'b00, SL_ADD, 16'h0999, 16'h0000, 1'b0, 1'b0);
        press(5'd1);
        check_all("a_cnt3", 2'b00, SL_ADD, 16'h9991, 16'h0000, 1'b0, 1'b0);
        press(5'd2);
        check("a_full.key_err", key_err, 1'b1);
        idle();
        check("a_full.err_drop", key_err, 1'b0);
        press(K_BAD);
        check_all("bad_a", 2'b00, SL_ADD, 16'h9991, 16'h0000, 1'b0, 1'b1);
        press(K_EQ);
        check_all("eq_in_a", 2'b00, SL_ADD, 16'h9991, 16'h0000, 1'b0, 1'b1);
        press(K_CLR);
        press(K_BS);
        check_all("bs_empty", 2'b00, SL_ADD, 16'h0000, 16'h0000, 1'b0, 1'b0);

        // operator replacement, rejects in ENTRY_B and RESULT
        press(5'd3); press(K_OR);
        check("or.ST_L", ST_L, SL_OR);
        press(K_AND);
        check_all("and", 2'b01, SL_AND, 16'h0003, 16'h0000, 1'b0, 1'b0);
        press(K_BAD);
        check_all("bad_b", 2'b01, SL_AND, 16'h0003, 16'h0000, 1'b0, 1'b1);
        press(5'd6);
        check_all("b6", 2'b01, SL_AND, 16'h0003, 16'h0006, 1'b0, 1'b0);
        result = 16'h2000;
        press(K_EQ);
        check_all("eq2", 2'b10, SL_AND, 16'h0003, 16'h0006, 1'b1, 1'b0);
        check("eq2.disp", disp, 16'h0002);
        press(K_BAD);
        check_all("bad_r", 2'b10, SL_AND, 16'h0003, 16'h0006, 1'b0, 1'b1);
        press(K_BS);
        check_all("bs_r", 2'b10, SL_AND, 16'h0003, 16'h0006, 1'b0, 1'b1);
        press(5'd2);
        check_all("r_digit", 2'b00, SL_AND, 16'h0002, 16'h0000, 1'b0, 1'b0);
        press(5'd3); press(5'd4); press(5'd5);
        check("r_digit_cnt", {A1, A2, A3, A4}, 16'h2345);
        press(5'd6);
        check("r_digit_full", key_err, 1'b1);

        // EQUALS with empty B
        press(K_ADD); press(K_EQ);
        check_all("eq_empty_b", 2'b10, SL_ADD, 16'h2345, 16'h0000, 1'b1, 1'b0);

        // asynchronous reset mid-entry, strobe on release edge
        press(K_CLR); press(5'd1); press(K_ADD); press(5'd7);
        check_all("pre_rst", 2'b01, SL_ADD, 16'h0001, 16'h0007, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_all("async_rst", 2'b00, SL_ADD, 16'h0000, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1; key_valid = 1'b1; key_code = 5'd5;
        @(posedge clk); #1;
        key_valid = 1'b0;
        check_all("release_key", 2'b00, SL_ADD, 16'h0005, 16'h0000, 1'b0, 1'b0);

        // CLEAR from RESULT
        press(K_SUB); press(5'd8); press(K_EQ);
        check("pre_clr.ST", ST, 2'b10);
        press(K_CLR);
        check_all("clr_result", 2'b00, SL_ADD, 16'h0000, 16'h0000, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
